// File: rtl/cl_word_unpacker_pkg.sv
// Shared GLM package for the cache-line to word unpacker.
// Holds the unpacker FSM state type, the words-per-line constant and the
// bundles a parent uses to wire the clfifo read port and wordfifo write port.
package cl_word_unpacker_pkg;

    localparam int CL_LINE_W      = 512;
    localparam int CL_WORD_W      = 32;
    localparam int WORDS_PER_LINE = CL_LINE_W / CL_WORD_W;

    typedef enum logic [1:0] {
        UNPACK_IDLE = 2'd0,
        UNPACK_RUN  = 2'd1,
        UNPACK_DONE = 2'd2
    } t_unpackstate;

    // clfifo read side as seen by the unpacker (tready flows back to clfifo)
    typedef struct packed {
        logic [CL_LINE_W-1:0] tdata;
        logic                 tvalid;
        logic                 tready;
    } clfifo_read_t;

    // wordfifo write side (almostfull flows back to the unpacker)
    typedef struct packed {
        logic                 we;
        logic [CL_WORD_W-1:0] wdata;
        logic                 almostfull;
    } wordfifo_write_t;

endpackage

// File: rtl/cl_word_unpacker.sv
// cl_word_unpacker
// Pops cache lines from clfifo and serialises each into WORDS_PER_LINE words
// for wordfifo, emitting exactly num_words words per job.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start, num_words  job start pulse (sampled in IDLE) and word count
//   busy, done        job in progress / 1-cycle completion pulse
//   cl_tdata/tvalid/tready  clfifo read port (pop on tvalid && tready)
//   wf_almostfull     wordfifo backpressure
//   wf_we, wf_wdata   registered wordfifo write port
module cl_word_unpacker
    import cl_word_unpacker_pkg::*;
#(
    parameter int LINE_WIDTH  = 512,
    parameter int WORD_WIDTH  = 32,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] num_words,
    output logic                   busy,
    output logic                   done,
    input  logic [LINE_WIDTH-1:0]  cl_tdata,
    input  logic                   cl_tvalid,
    output logic                   cl_tready,
    input  logic                   wf_almostfull,
    output logic                   wf_we,
    output logic [WORD_WIDTH-1:0]  wf_wdata
);

    localparam int WPL   = LINE_WIDTH / WORD_WIDTH;
    localparam int IDX_W = $clog2(WPL);

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]       IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]       IDX_LAST = {IDX_W{1'b1}};

    // ceil(n / WPL) without forming n + WPL - 1, so n = 2^COUNT_WIDTH-1 is safe
    function automatic logic [COUNT_WIDTH-1:0] lines_for(input logic [COUNT_WIDTH-1:0] n);
        return (n >> IDX_W) + {{(COUNT_WIDTH-1){1'b0}}, |n[IDX_W-1:0]};
    endfunction

    t_unpackstate           state_q, state_d;
    logic [LINE_WIDTH-1:0]  buf_q, buf_d;
    logic                   buf_valid_q, buf_valid_d;
    logic [IDX_W-1:0]       word_idx_q, word_idx_d;
    logic [COUNT_WIDTH-1:0] words_left_q, words_left_d;
    logic [COUNT_WIDTH-1:0] lines_left_q, lines_left_d;
    logic                   wf_we_q, wf_we_d;
    logic [WORD_WIDTH-1:0]  wf_wdata_q, wf_wdata_d;

    logic                   run;
    logic                   emit;
    logic                   last_word;
    logic                   last_emit;
    logic                   pop;
    logic [WORD_WIDTH-1:0]  word_sel;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= UNPACK_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            UNPACK_IDLE: begin
                if (start) begin
                    state_d = (num_words == '0) ? UNPACK_DONE : UNPACK_RUN;
                end
            end
            UNPACK_RUN: begin
                // the final word's write is decided this cycle
                if (emit && (words_left_q == CNT_ONE)) begin
                    state_d = UNPACK_DONE;
                end
            end
            UNPACK_DONE: state_d = UNPACK_IDLE;
            default:     state_d = UNPACK_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        run  = (state_q == UNPACK_RUN);
        busy = (state_q != UNPACK_IDLE);
        done = (state_q == UNPACK_DONE);
    end

    // 16:1 word select from the line buffer
    always_comb begin
        word_sel = '0;
        for (int i = 0; i < WPL; i++) begin
            if (word_idx_q == IDX_W'(i)) begin
                word_sel = buf_q[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    // Datapath control: emit, pop and counter updates
    always_comb begin
        emit      = run && buf_valid_q && !wf_almostfull;
        last_word = (word_idx_q == IDX_LAST) || (words_left_q == CNT_ONE);
        last_emit = emit && last_word;
        // refill is allowed while the last word of the current line goes out,
        // which keeps the word stream gap-free across line boundaries
        cl_tready = run && (lines_left_q != '0) && (!buf_valid_q || last_emit);
        pop       = cl_tready && cl_tvalid;

        buf_d        = buf_q;
        buf_valid_d  = buf_valid_q;
        word_idx_d   = word_idx_q;
        words_left_d = words_left_q;
        lines_left_d = lines_left_q;
        wf_we_d      = emit;
        wf_wdata_d   = emit ? word_sel : wf_wdata_q;

        if ((state_q == UNPACK_IDLE) && start) begin
            words_left_d = num_words;
            lines_left_d = lines_for(num_words);
        end

        if (emit) begin
            words_left_d = words_left_q - CNT_ONE;
            word_idx_d   = word_idx_q + IDX_ONE;
            // words past words_left in a partial line are simply dropped here
            if (last_word) begin
                buf_valid_d = 1'b0;
            end
        end

        if (pop) begin
            buf_d        = cl_tdata;
            buf_valid_d  = 1'b1;
            word_idx_d   = '0;
            lines_left_d = lines_left_q - CNT_ONE;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid_q  <= 1'b0;
            word_idx_q   <= '0;
            words_left_q <= '0;
            lines_left_q <= '0;
            wf_we_q      <= 1'b0;
            wf_wdata_q   <= '0;
        end else begin
            buf_valid_q  <= buf_valid_d;
            word_idx_q   <= word_idx_d;
            words_left_q <= words_left_d;
            lines_left_q <= lines_left_d;
            wf_we_q      <= wf_we_d;
            wf_wdata_q   <= wf_wdata_d;
        end
    end

    // Line buffer payload; qualified by buf_valid_q, so no reset needed
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign wf_we    = wf_we_q;
    assign wf_wdata = wf_wdata_q;

endmodule
